bcd_tube_feeder: RTL and testbench

BCD_TUBE_FEEDER -- requirements
Module: bcd_tube_feeder

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_dabble_step.sv | 21 ++
 rtl/bcd_tube_feeder.sv | 101 ++++++++++
 tb/tb_bcd_tube_feeder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digital-tube feeder: FSM encoding, iteration
// count, overflow display pattern, default operand limit and byte-merge helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned ITER            = 32;
  localparam logic [31:0] OVF_PATTERN     = 32'hEEEE_EEEE;
  localparam logic [31:0] MAX_VAL_DEFAULT = 32'd99_999_999;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left
// taking one new binary bit in at the LSB.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [31:0] acc,
  input  logic        bit_in,
  output logic [31:0] acc_next
);

  logic [31:0] adj;

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = (adj << 1) | {31'b0, bit_in};
  end

endmodule

// File: rtl/bcd_tube_feeder.sv
// CPU-visible binary-to-BCD converter that feeds an 8-digit tube register:
// a VALUE write launches a 32-step conversion, then one write to the tube.
module bcd_tube_feeder
  import bcd_pkg::*;
#(
  parameter logic        DT_ADDR = 1'b0,
  parameter logic [31:0] MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        dt_addr,
  output logic [3:0]  dt_byteen,
  output logic [31:0] dt_din
);

  localparam logic [4:0] LAST_STEP = 5'(ITER - 1);

  state_t      state, state_n;
  logic [31:0] operand, operand_n;
  logic [31:0] shadow, shadow_n;
  logic [31:0] acc, acc_n;
  logic [4:0]  cnt, cnt_n;
  logic        ovf, ovf_n;
  logic [31:0] dt_din_n;
  logic [31:0] merged;
  logic [31:0] step_out;
  logic        value_wr;
  logic        busy;

  bcd_dabble_step u_step (
    .acc      (acc),
    .bit_in   (shadow[31]),
    .acc_next (step_out)
  );

  assign value_wr = (|cpu_byteen) && !cpu_addr;
  assign merged   = byte_merge(operand, cpu_din, cpu_byteen);
  assign busy     = (state != IDLE);
  assign dt_addr  = DT_ADDR;
  assign cpu_dout = cpu_addr ? {30'b0, ovf, busy} : operand;
  // A VALUE write landing in the WRITE cycle supersedes this result, so suppress it.
  assign dt_byteen = (state == WRITE && !value_wr) ? 4'hF : 4'h0;

  always_comb begin
    state_n   = state;
    operand_n = operand;
    shadow_n  = shadow;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    dt_din_n  = dt_din;
    if (value_wr) begin
      state_n   = CONV;
      operand_n = merged;
      shadow_n  = merged;
      acc_n     = '0;
      cnt_n     = '0;
      ovf_n     = (merged > MAX_VAL);
    end else begin
      case (state)
        IDLE: ;
        CONV: begin
          acc_n    = step_out;
          shadow_n = {shadow[30:0], 1'b0};
          cnt_n    = cnt + 5'd1;
          if (cnt == LAST_STEP) begin
            state_n  = WRITE;
            dt_din_n = ovf ? OVF_PATTERN : step_out;
          end
        end
        WRITE:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      operand <= '0;
      shadow  <= '0;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      dt_din  <= '0;
    end else begin
      state   <= state_n;
      operand <= operand_n;
      shadow  <= shadow_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      dt_din  <= dt_din_n;
    end
  end

endmodule

// File: tb/tb_bcd_tube_feeder.sv
// Directed bench for bcd_tube_feeder: table of VALUE writes with hand-computed
// BCD results, plus hand sequences for busy timing, restart, reset and STATUS.
module tb_bcd_tube_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        dt_addr;
  logic [3:0]  dt_byteen;
  logic [31:0] dt_din;

  bcd_tube_feeder #(.DT_ADDR(1'b0), .MAX_VAL(32'd99_999_999)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_byteen (cpu_byteen),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .dt_addr    (dt_addr),
    .dt_byteen  (dt_byteen),
    .dt_din     (dt_din)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          dt_cnt = 0;
  int          dt_cyc = -1;
  logic [31:0] dt_val = '0;
  logic [3:0]  dt_be = '0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dt_byteen != 4'h0) begin
      dt_cnt <= dt_cnt + 1;
      dt_cyc <= cyc;
      dt_val <= dt_din;
      dt_be  <= dt_byteen;
    end
  end

  typedef struct {
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] exp_op;
    logic [31:0] exp_dt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge: drives the write for cycle t, returns at negedge of t+1.
  task automatic wr(input logic a, input logic [3:0] be, input logic [31:0] d, output int t);
    cpu_addr   = a;
    cpu_byteen = be;
    cpu_din    = d;
    t = cyc;
    @(negedge clk);
    cpu_addr   = 1'b0;
    cpu_byteen = 4'h0;
    cpu_din    = '0;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    cpu_addr = a;
    #1;
    v = cpu_dout;
    cpu_addr = 1'b0;
  endtask

  initial begin
    int          t, t2, base;
    logic [31:0] v;

    vecs[0] = '{4'hF, 32'd1234,        32'd1234,        32'h0000_1234, 1'b0};
    vecs[1] = '{4'hF, 32'd99_999_999,  32'd99_999_999,  32'h9999_9999, 1'b0};
    vecs[2] = '{4'hF, 32'd100_000_000, 32'd100_000_000, 32'hEEEE_EEEE, 1'b1};
    vecs[3] = '{4'hF, 32'd0,           32'd0,           32'h0000_0000, 1'b0};
    vecs[4] = '{4'b0001, 32'h0000_00FF, 32'h0000_00FF,  32'h0000_0255, 1'b0};
    vecs[5] = '{4'b0100, 32'h0012_3400, 32'h0012_00FF,  32'h0117_9903, 1'b0};
    vecs[6] = '{4'b1100, 32'hFFFF_0000, 32'hFFFF_00FF,  32'hEEEE_EEEE, 1'b1};
    vecs[7] = '{4'hF, 32'd87_654_321,  32'd87_654_321,  32'h8765_4321, 1'b0};
    vecs[8] = '{4'hF, 32'd1234,        32'd1234,        32'h0000_1234, 1'b0};
    vecs[9] = '{4'b0010, 32'h0000_0300, 32'h0000_03D2,  32'h0000_0978, 1'b0};

    reset = 1'b1; cpu_addr = 1'b0; cpu_byteen = 4'h0; cpu_din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_dt_byteen", {28'b0, dt_byteen}, 32'h0);
    chk("rst_dt_din", dt_din, 32'h0);
    chk("rst_dt_addr", {31'b0, dt_addr}, 32'h0);
    rd(1'b0, v); chk("rst_value", v, 32'h0);
    rd(1'b1, v); chk("rst_status", v, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      base = dt_cnt;
      wr(1'b0, vecs[i].be, vecs[i].din, t);
      repeat (40) @(negedge clk);
      chk($sformatf("v%0d_dt_count", i), dt_cnt - base, 32'd1);
      chk($sformatf("v%0d_dt_cycle", i), dt_cyc - t, 32'd33);
      chk($sformatf("v%0d_dt_din", i), dt_val, vecs[i].exp_dt);
      rd(1'b1, v); chk($sformatf("v%0d_status", i), v, {30'b0, vecs[i].exp_ovf, 1'b0});
      rd(1'b0, v); chk($sformatf("v%0d_value", i), v, vecs[i].exp_op);
    end

    // busy and dt_byteen cycle-by-cycle around a 1234 conversion
    base = dt_cnt;
    wr(1'b0, 4'hF, 32'd1234, t);
    while (cyc <= t + 35) begin
      rd(1'b1, v);
      chk($sformatf("busy_T+%0d", cyc - t), {31'b0, v[0]},
          {31'b0, (cyc - t >= 1) && (cyc - t <= 33)});
      chk($sformatf("dt_be_T+%0d", cyc - t), {28'b0, dt_byteen},
          (cyc - t == 33) ? 32'hF : 32'h0);
      if (cyc - t == 33) chk("busy_seq_dt_din", dt_din, 32'h0000_1234);
      @(negedge clk);
    end
    chk("busy_seq_dt_count", dt_cnt - base, 32'd1);

    // STATUS during an overflowing conversion
    base = dt_cnt;
    wr(1'b0, 4'hF, 32'd100_000_000, t);
    repeat (4) @(negedge clk);
    rd(1'b1, v); chk("ovf_status_busy", v, 32'h3);
    repeat (36) @(negedge clk);
    chk("ovf_dt_din", dt_val, 32'hEEEE_EEEE);
    chk("ovf_dt_count", dt_cnt - base, 32'd1);

    // restart mid-conversion: only the second operand reaches the tube
    base = dt_cnt;
    wr(1'b0, 4'hF, 32'd5, t);
    while (cyc < t + 10) @(negedge clk);
    wr(1'b0, 4'hF, 32'd42, t2);
    chk("restart_launch_cycle", t2 - t, 32'd10);
    repeat (40) @(negedge clk);
    chk("restart_dt_count", dt_cnt - base, 32'd1);
    chk("restart_dt_cycle", dt_cyc - t, 32'd43);
    chk("restart_dt_din", dt_val, 32'h0000_0042);
    rd(1'b1, v); chk("restart_status", v, 32'h0);

    // reset mid-conversion, together with a VALUE write
    base = dt_cnt;
    wr(1'b0, 4'hF, 32'd7, t);
    while (cyc < t + 10) @(negedge clk);
    reset = 1'b1; cpu_addr = 1'b0; cpu_byteen = 4'hF; cpu_din = 32'd55;
    @(negedge clk);
    reset = 1'b0; cpu_byteen = 4'h0; cpu_din = '0;
    repeat (40) @(negedge clk);
    chk("reset_dt_count", dt_cnt - base, 32'd0);
    chk("reset_dt_byteen", {28'b0, dt_byteen}, 32'h0);
    chk("reset_dt_din", dt_din, 32'h0);
    rd(1'b1, v); chk("reset_status", v, 32'h0);
    rd(1'b0, v); chk("reset_value", v, 32'h0);

    // STATUS write in IDLE is ignored
    wr(1'b0, 4'hF, 32'd321, t);
    repeat (40) @(negedge clk);
    base = dt_cnt;
    wr(1'b1, 4'hF, 32'hFFFF_FFFF, t);
    repeat (3) @(negedge clk);
    rd(1'b1, v); chk("status_wr_status", v, 32'h0);
    repeat (37) @(negedge clk);
    chk("status_wr_dt_count", dt_cnt - base, 32'd0);
    rd(1'b0, v); chk("status_wr_value", v, 32'd321);
    chk("status_wr_dt_din", dt_din, 32'h0000_0321);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
